alu_share_arbiter: RTL and testbench

- Shares the single CPU ALU between two requesters: the fetch stage (PC increment) and the execute stage (register/immediate operation).
- Picks one winner per cycle with round-robin arbitration, drives the ALU inputs combinationally from the winner, and registers the ALU result.
- Returns the registered result to the winner with a one-cycle response strobe.
- Sits between the fetch/execute control logic and the ALU instance in the non-pipelined core.

---
 rtl/alu_share_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
// Shares the single core ALU between the fetch stage (PC increment) and the
// execute stage. One winner per cycle is chosen round-robin, the ALU inputs
// are driven combinationally from that winner, and the ALU result is
// registered and handed back to the winner with a one-cycle strobe.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             fetch_req_i,
    input  logic [WIDTH-1:0] fetch_a_i,
    input  logic [WIDTH-1:0] fetch_b_i,
    output logic             fetch_gnt_o,
    output logic             fetch_rsp_valid_o,

    input  logic             ex_req_i,
    input  logic [WIDTH-1:0] ex_a_i,
    input  logic [WIDTH-1:0] ex_b_i,
    input  logic [2:0]       ex_funct3_i,
    input  logic             ex_funct7_i,
    output logic             ex_gnt_o,
    output logic             ex_rsp_valid_o,

    input  logic             flush_i,
    output logic [WIDTH-1:0] rsp_data_o,

    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [2:0]       alu_funct3_o,
    output logic             alu_funct7_o,
    output logic             alu_pc_add_o,
    input  logic [WIDTH-1:0] alu_c_i
);

    // Encoding of the last winner; the reset value makes execute win the
    // first tie after reset.
    localparam logic LAST_FETCH = 1'b0;
    localparam logic LAST_EX    = 1'b1;

    logic             last_gnt;
    logic             fetch_win;
    logic             ex_win;
    logic             fetch_rsp_valid_q;
    logic             ex_rsp_valid_q;
    logic [WIDTH-1:0] rsp_data_q;

    // Round-robin pick: a lone requester wins outright, a tie goes to the
    // requester that did not win last time.
    always_comb begin
        fetch_win = 1'b0;
        ex_win    = 1'b0;
        if (fetch_req_i && ex_req_i) begin
            if (last_gnt == LAST_EX) begin
                fetch_win = 1'b1;
            end else begin
                ex_win = 1'b1;
            end
        end else if (fetch_req_i) begin
            fetch_win = 1'b1;
        end else if (ex_req_i) begin
            ex_win = 1'b1;
        end
    end

    // Steer the winner's operands onto the ALU; an idle ALU sees zero
    // operands with the add encoding so its output is quiet and predictable.
    always_comb begin
        alu_a_o      = '0;
        alu_b_o      = '0;
        alu_funct3_o = 3'b000;
        alu_funct7_o = 1'b1;
        alu_pc_add_o = 1'b0;
        if (fetch_win) begin
            alu_a_o      = fetch_a_i;
            alu_b_o      = fetch_b_i;
            alu_pc_add_o = 1'b1;
        end else if (ex_win) begin
            alu_a_o      = ex_a_i;
            alu_b_o      = ex_b_i;
            alu_funct3_o = ex_funct3_i;
            alu_funct7_o = ex_funct7_i;
        end
    end

    // Remember the winner only in cycles that actually granted someone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_gnt <= LAST_FETCH;
        end else if (fetch_win) begin
            last_gnt <= LAST_FETCH;
        end else if (ex_win) begin
            last_gnt <= LAST_EX;
        end
    end

    // Capture the ALU result at the end of a grant cycle and raise the
    // winner's strobe; a flush during an execute grant suppresses its strobe
    // while still loading the data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_data_q        <= '0;
            fetch_rsp_valid_q <= 1'b0;
            ex_rsp_valid_q    <= 1'b0;
        end else begin
            fetch_rsp_valid_q <= fetch_win;
            ex_rsp_valid_q    <= ex_win && !flush_i;
            if (fetch_win || ex_win) begin
                rsp_data_q <= alu_c_i;
            end
        end
    end

    assign fetch_gnt_o       = fetch_win;
    assign ex_gnt_o          = ex_win;
    assign rsp_data_o        = rsp_data_q;
    assign fetch_rsp_valid_o = fetch_rsp_valid_q;
    // A flush arriving in the response cycle still kills the execute strobe.
    assign ex_rsp_valid_o    = ex_rsp_valid_q && !flush_i;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter
// Scoreboard bench: a reference model decides each cycle's winner from the
// round-robin rules and pushes the expected response; a monitor pops one
// entry per cycle and compares it against the registered response.
module tb_alu_share_arbiter;

    localparam int WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             fetch_req_i;
    logic [WIDTH-1:0] fetch_a_i;
    logic [WIDTH-1:0] fetch_b_i;
    logic             fetch_gnt_o;
    logic             fetch_rsp_valid_o;
    logic             ex_req_i;
    logic [WIDTH-1:0] ex_a_i;
    logic [WIDTH-1:0] ex_b_i;
    logic [2:0]       ex_funct3_i;
    logic             ex_funct7_i;
    logic             ex_gnt_o;
    logic             ex_rsp_valid_o;
    logic             flush_i;
    logic [WIDTH-1:0] rsp_data_o;
    logic [WIDTH-1:0] alu_a_o;
    logic [WIDTH-1:0] alu_b_o;
    logic [2:0]       alu_funct3_o;
    logic             alu_funct7_o;
    logic             alu_pc_add_o;
    logic [WIDTH-1:0] alu_c_i;

    typedef struct {
        bit               fetch_valid;
        bit               ex_valid;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t             exp_q[$];
    int               check_count = 0;
    int               pass_count  = 0;
    bit               running     = 1'b0;
    bit               model_last_ex;
    logic [WIDTH-1:0] model_data;
    bit               fetch_taken = 1'b0;
    bit               ex_taken    = 1'b0;

    alu_share_arbiter #(.WIDTH(WIDTH)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .fetch_req_i       (fetch_req_i),
        .fetch_a_i         (fetch_a_i),
        .fetch_b_i         (fetch_b_i),
        .fetch_gnt_o       (fetch_gnt_o),
        .fetch_rsp_valid_o (fetch_rsp_valid_o),
        .ex_req_i          (ex_req_i),
        .ex_a_i            (ex_a_i),
        .ex_b_i            (ex_b_i),
        .ex_funct3_i       (ex_funct3_i),
        .ex_funct7_i       (ex_funct7_i),
        .ex_gnt_o          (ex_gnt_o),
        .ex_rsp_valid_o    (ex_rsp_valid_o),
        .flush_i           (flush_i),
        .rsp_data_o        (rsp_data_o),
        .alu_a_o           (alu_a_o),
        .alu_b_o           (alu_b_o),
        .alu_funct3_o      (alu_funct3_o),
        .alu_funct7_o      (alu_funct7_o),
        .alu_pc_add_o      (alu_pc_add_o),
        .alu_c_i           (alu_c_i)
    );

    always #5 clk_i = ~clk_i;

    // RV32-style ALU behaviour; funct7=1 selects add / logical right shift.
    function automatic logic [WIDTH-1:0] alu_ref(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [2:0] f3,
                                                 input logic f7,
                                                 input logic pc_add);
        int unsigned sh;
        sh = b % WIDTH;
        if (pc_add) return a + b;
        case (f3)
            3'b000: return f7 ? a + b : a - b;
            3'b001: return a << sh;
            3'b010: return ($signed(a) < $signed(b)) ? 1 : 0;
            3'b011: return (a < b) ? 1 : 0;
            3'b100: return a ^ b;
            3'b101: return f7 ? (a >> sh) : WIDTH'($signed(a) >>> sh);
            3'b110: return a | b;
            default: return a & b;
        endcase
    endfunction

    // The ALU instance the block would normally drive.
    assign alu_c_i = alu_ref(alu_a_o, alu_b_o, alu_funct3_o, alu_funct7_o, alu_pc_add_o);

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit freq, input logic [WIDTH-1:0] fa,
                                 input logic [WIDTH-1:0] fb, input bit ereq,
                                 input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb,
                                 input logic [2:0] f3, input bit f7, input bit fl);
        rst_i       = rst;
        fetch_req_i = freq;
        fetch_a_i   = fa;
        fetch_b_i   = fb;
        ex_req_i    = ereq;
        ex_a_i      = ea;
        ex_b_i      = eb;
        ex_funct3_i = f3;
        ex_funct7_i = f7;
        flush_i     = fl;
        @(posedge clk_i);
        #1;
    endtask

    // Reference model: evaluate the round-robin rules on this cycle's
    // requests, check grants and ALU drive, and queue the expected response.
    always @(negedge clk_i) begin : model_blk
        bit               wf, we;
        logic [WIDTH-1:0] ea, eb, res;
        logic [2:0]       ef3;
        logic             ef7, epc;
        exp_t             ent;
        if (running) begin
            we = ex_req_i && (!fetch_req_i || !model_last_ex);
            wf = fetch_req_i && !we;
            ea = '0; eb = '0; ef3 = 3'b000; ef7 = 1'b1; epc = 1'b0;
            if (wf) begin
                ea = fetch_a_i; eb = fetch_b_i; epc = 1'b1;
            end else if (we) begin
                ea = ex_a_i; eb = ex_b_i; ef3 = ex_funct3_i; ef7 = ex_funct7_i;
            end
            checkOutput("fetch_gnt", WIDTH'(fetch_gnt_o), WIDTH'(wf));
            checkOutput("ex_gnt", WIDTH'(ex_gnt_o), WIDTH'(we));
            checkOutput("alu_a", alu_a_o, ea);
            checkOutput("alu_b", alu_b_o, eb);
            checkOutput("alu_funct3", WIDTH'(alu_funct3_o), WIDTH'(ef3));
            checkOutput("alu_funct7", WIDTH'(alu_funct7_o), WIDTH'(ef7));
            checkOutput("alu_pc_add", WIDTH'(alu_pc_add_o), WIDTH'(epc));
            res = wf ? fetch_a_i + fetch_b_i
                     : alu_ref(ex_a_i, ex_b_i, ex_funct3_i, ex_funct7_i, 1'b0);
            if (rst_i) begin
                model_last_ex = 1'b0;
                model_data    = '0;
                ent = '{fetch_valid: 1'b0, ex_valid: 1'b0, data: '0};
            end else if (wf || we) begin
                model_last_ex = we;
                model_data    = res;
                ent = '{fetch_valid: wf, ex_valid: we && !flush_i, data: res};
            end else begin
                ent = '{fetch_valid: 1'b0, ex_valid: 1'b0, data: model_data};
            end
            exp_q.push_back(ent);
            fetch_taken = wf;
            ex_taken    = we;
        end
    end

    // Monitor: after each edge, pop the expectation for the cycle just ended
    // and compare the registered response and strobes.
    always @(posedge clk_i) begin : monitor_blk
        exp_t ent;
        #2;
        if (exp_q.size() != 0) begin
            ent = exp_q.pop_front();
            checkOutput("fetch_rsp_valid", WIDTH'(fetch_rsp_valid_o), WIDTH'(ent.fetch_valid));
            checkOutput("ex_rsp_valid", WIDTH'(ex_rsp_valid_o), WIDTH'(ent.ex_valid && !flush_i));
            checkOutput("rsp_data", rsp_data_o, ent.data);
        end
    end

    initial begin : stim_blk
        bit               fr, er, fl, rs;
        logic [WIDTH-1:0] fa, fb, xa, xb;
        logic [2:0]       f3;
        bit               f7;
        rst_i = 1'b1; fetch_req_i = 1'b0; fetch_a_i = '0; fetch_b_i = '0;
        ex_req_i = 1'b0; ex_a_i = '0; ex_b_i = '0; ex_funct3_i = 3'b000;
        ex_funct7_i = 1'b0; flush_i = 1'b0;
        model_last_ex = 1'b0;
        model_data    = '0;
        #1;
        running = 1'b1;
        $display("[TB] starting directed sequence");

        // Reset, fetch PC add, then idle so the 0x104 result must hold.
        applyStimulus(1, 0, 0, 4, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 4, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 32'h100, 4, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Execute-only subtract 7 - 3.
        applyStimulus(0, 0, 0, 0, 1, 7, 3, 3'b000, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset, then both requesting for four cycles: E, F, E, F.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            applyStimulus(0, 1, 32'h200 + 4 * i, 4, 1, 10 + i, 2, 3'b110, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Flush in the grant cycle, then flush only in the response cycle.
        applyStimulus(0, 0, 0, 0, 1, 5, 9, 3'b100, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 5, 9, 3'b000, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Win a grant for fetch, then reset during a grant; next tie goes to execute.
        applyStimulus(0, 1, 32'h40, 4, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 1, 32'h44, 4, 1, 1, 1, 3'b000, 1, 0);
        applyStimulus(0, 1, 32'h44, 4, 1, 1, 1, 3'b000, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] starting random sequence");
        fr = 0; er = 0; fa = 0; fb = 4; xa = 0; xb = 0; f3 = 0; f7 = 1;
        for (int c = 0; c < 3000; c++) begin
            // A requester keeps its request and operands until the model saw
            // it granted; only then may it drop or issue something new.
            if (!fr || fetch_taken) begin
                fr = ($urandom_range(0, 3) != 0);
                fa = $urandom;
                fb = ($urandom_range(0, 3) == 0) ? $urandom : 32'd4;
            end
            if (!er || ex_taken) begin
                er = ($urandom_range(0, 3) != 0);
                xa = $urandom;
                xb = ($urandom_range(0, 1) == 0) ? $urandom : $urandom_range(0, 40);
                f3 = 3'($urandom_range(0, 7));
                f7 = 1'($urandom_range(0, 1));
            end
            fl = ($urandom_range(0, 7) == 0);
            rs = ($urandom_range(0, 199) == 0);
            if (rs) begin
                fr = 0;
                er = 0;
            end
            applyStimulus(rs, fr, fa, fb, er, xa, xb, f3, f7, fl);
        end

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        running = 1'b0;
        @(posedge clk_i);
        #3;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
